// File: rtl/simple_bus_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin bus arbiter.
// master = arbiter side (drives grants), slave = requester side (drives req/done).
interface simple_bus_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            timeout_err;

  modport master (
    input  req, done,
    output gnt, gnt_id, busy, timeout_err
  );

  modport slave (
    output req, done,
    input  gnt, gnt_id, busy, timeout_err
  );
endinterface

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter for one shared bus: req sampled at edge N gives registered gnt in cycle N+1.
// No preemption; a grant ends on done, req drop or TIMEOUT, then one dead RELEASE cycle.
module simple_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  simple_bus_arbiter_if.master bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   hold_cnt;

  logic [IDW-1:0]  winner;
  logic            found;
  int              scan_idx;

  logic            done_g;
  logic            req_g;
  logic            at_limit;
  logic [IDW-1:0]  rr_next;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && bus.req[scan_idx]) begin
        winner = IDW'(scan_idx);
        found  = 1'b1;
      end
    end
  end

  assign done_g   = bus.done[bus.gnt_id];
  assign req_g    = bus.req[bus.gnt_id];
  assign at_limit = (hold_cnt == HOLD_LAST);
  assign rr_next  = (bus.gnt_id == IDW'(NREQ - 1)) ? '0 : bus.gnt_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      hold_cnt        <= '0;
      bus.gnt         <= '0;
      bus.gnt_id      <= '0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.gnt    <= NREQ'(1) << winner;
            bus.gnt_id <= winner;
            bus.busy   <= 1'b1;
            hold_cnt   <= '0;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (done_g || !req_g || at_limit) begin
            bus.gnt         <= '0;
            bus.busy        <= 1'b0;
            rr_ptr          <= rr_next;
            hold_cnt        <= '0;
            // A completion on the limit cycle is a normal release, not a timeout.
            bus.timeout_err <= at_limit && !done_g && req_g;
            state           <= RELEASE;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Bench for simple_bus_arbiter: expected grantees queued when requests are driven,
// popped and compared as each grant appears.
module tb_simple_bus_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  simple_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  simple_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int expq[$];

  // Outputs are examined 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a grant; zeros = cycles seen with gnt==0 before it.
  task automatic wait_grant(output logic [3:0] g, output int zeros);
    zeros = 0;
    g     = '0;
    for (int i = 0; i < 200; i++) begin
      if (bus.gnt != '0) begin
        g = bus.gnt;
        return;
      end
      zeros++;
      tick();
    end
    total++;
    bad++;
    $display("FAIL wait_grant got=no grant within 200 cycles exp=grant");
  endtask

  function automatic int pop_exp();
    if (expq.size() == 0) return -1;
    return expq.pop_front();
  endfunction

  task automatic test_reset();
    bus.req  = 4'b1111;
    bus.done = '0;
    rst      = 1'b1;
    tick();
    tick();
    total++;
    if (bus.gnt !== 4'b0000 || bus.gnt_id !== 2'd0 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got=gnt %b id %0d busy %b terr %b exp=0 0 0 0",
               bus.gnt, bus.gnt_id, bus.busy, bus.timeout_err);
    end
    bus.req = '0;
    rst     = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] g;
    int z, e;
    do_reset();
    bus.req = 4'b0100;
    expq.push_back(2);
    tick();
    total++;
    if (bus.gnt !== 4'b0100) begin
      bad++;
      $display("FAIL single_latency got=%b exp=0100", bus.gnt);
    end
    wait_grant(g, z);
    e = pop_exp();
    total++;
    if (int'(bus.gnt_id) != e || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL single_id got=%0d busy %b exp=%0d busy 1", bus.gnt_id, bus.busy, e);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      total++;
      if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1) begin
        bad++;
        $display("FAIL single_hold_c%0d got=%b busy %b exp=0100 busy 1", c, bus.gnt, bus.busy);
      end
    end
    bus.done = 4'b0100;
    bus.req  = '0;
    tick();
    bus.done = '0;
    total++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL single_release got=%b busy %b terr %b exp=0000 0 0", bus.gnt, bus.busy, bus.timeout_err);
    end
    tick();
    total++;
    if (bus.gnt !== 4'b0000 || bus.gnt_id !== 2'd2) begin
      bad++;
      $display("FAIL single_after got=%b id %0d exp=0000 id 2", bus.gnt, bus.gnt_id);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    int z, e;
    do_reset();
    bus.req = 4'b1111;
    expq.push_back(0);
    expq.push_back(1);
    expq.push_back(2);
    expq.push_back(3);
    expq.push_back(0);
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, z);
      e = pop_exp();
      total++;
      if (int'(bus.gnt_id) != e || bus.gnt !== (4'b0001 << e)) begin
        bad++;
        $display("FAIL rr_order_%0d got=id %0d gnt %b exp=id %0d", n, bus.gnt_id, bus.gnt, e);
      end
      if (n > 0) begin
        total++;
        if (z < 1 || z > 2) begin
          bad++;
          $display("FAIL rr_gap_%0d got=%0d idle cycles exp=1..2", n, z);
        end
      end
      bus.done = bus.gnt;
      tick();
      bus.done = '0;
      total++;
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL rr_release_%0d got=%b busy %b exp=0000 0", n, bus.gnt, bus.busy);
      end
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic [3:0] g;
    int z, e, cnt;
    do_reset();
    bus.req = 4'b0001;
    expq.push_back(0);
    wait_grant(g, z);
    e = pop_exp();
    total++;
    if (int'(bus.gnt_id) != e) begin
      bad++;
      $display("FAIL to_first_id got=%0d exp=%0d", bus.gnt_id, e);
    end
    cnt = 0;
    while (bus.gnt != '0 && cnt < 300) begin
      total++;
      if (bus.timeout_err !== 1'b0) begin
        bad++;
        $display("FAIL to_early_err got=1 exp=0 at hold cycle %0d", cnt + 1);
      end
      cnt++;
      tick();
    end
    total++;
    if (cnt != TIMEOUT) begin
      bad++;
      $display("FAIL to_hold_len got=%0d exp=%0d", cnt, TIMEOUT);
    end
    total++;
    if (bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_err_pulse got=%b exp=1", bus.timeout_err);
    end
    tick();
    total++;
    if (bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_err_width got=%b exp=0", bus.timeout_err);
    end
    expq.push_back(0);
    wait_grant(g, z);
    e = pop_exp();
    total++;
    if (int'(bus.gnt_id) != e || bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL to_regrant got=id %0d gnt %b exp=id %0d", bus.gnt_id, bus.gnt, e);
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_boundary();
    logic [3:0] g;
    int z, e, k;
    do_reset();
    bus.req = 4'b0011;
    expq.push_back(0);
    wait_grant(g, z);
    e = pop_exp();
    total++;
    if (int'(bus.gnt_id) != e) begin
      bad++;
      $display("FAIL bnd_id got=%0d exp=%0d", bus.gnt_id, e);
    end
    k = 1;
    bus.done = 4'b0010;
    tick();
    k++;
    bus.done = '0;
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL bnd_stray_done got=%b exp=0001", bus.gnt);
    end
    while (k < TIMEOUT) begin
      tick();
      k++;
    end
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL bnd_held_to_limit got=%b exp=0001", bus.gnt);
    end
    bus.done = 4'b0001;
    tick();
    bus.done = '0;
    total++;
    if (bus.gnt !== 4'b0000 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL bnd_done_at_limit got=gnt %b terr %b exp=0000 0", bus.gnt, bus.timeout_err);
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    int z, e;
    do_reset();
    bus.req = 4'b0010;
    expq.push_back(1);
    wait_grant(g, z);
    e = pop_exp();
    total++;
    if (int'(bus.gnt_id) != e || bus.gnt !== 4'b0010) begin
      bad++;
      $display("FAIL rmid_grant got=id %0d gnt %b exp=id %0d", bus.gnt_id, bus.gnt, e);
    end
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0 || bus.gnt_id !== 2'd0) begin
      bad++;
      $display("FAIL rmid_reset got=gnt %b busy %b terr %b id %0d exp=0000 0 0 0",
               bus.gnt, bus.busy, bus.timeout_err, bus.gnt_id);
    end
    bus.req = 4'b0011;
    tick();
    rst = 1'b0;
    expq.push_back(0);
    wait_grant(g, z);
    e = pop_exp();
    total++;
    if (int'(bus.gnt_id) != e || bus.gnt !== 4'b0001) begin
      bad++;
      $display("FAIL rmid_after got=id %0d gnt %b exp=id %0d", bus.gnt_id, bus.gnt, e);
    end
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_drop();
    logic [3:0] g;
    int z, e;
    do_reset();
    bus.req = 4'b0100;
    expq.push_back(2);
    wait_grant(g, z);
    e = pop_exp();
    total++;
    if (int'(bus.gnt_id) != e) begin
      bad++;
      $display("FAIL drop_grant got=%0d exp=%0d", bus.gnt_id, e);
    end
    tick();
    bus.req = '0;
    tick();
    total++;
    if (bus.gnt !== 4'b0000 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL drop_release got=gnt %b terr %b exp=0000 0", bus.gnt, bus.timeout_err);
    end
    // rr_ptr is now 3, so requester 3 beats requester 0.
    bus.req = 4'b1001;
    expq.push_back(3);
    wait_grant(g, z);
    e = pop_exp();
    total++;
    if (int'(bus.gnt_id) != e || bus.gnt !== 4'b1000) begin
      bad++;
      $display("FAIL drop_rr_next got=id %0d gnt %b exp=id %0d", bus.gnt_id, bus.gnt, e);
    end
    bus.done = bus.gnt;
    bus.req  = '0;
    tick();
    bus.done = '0;
    tick();
  endtask

  initial begin
    bus.req  = '0;
    bus.done = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_drop();
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d left exp=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Invariant: grant is one-hot or zero, busy mirrors it.
  always @(negedge clk) begin
    if (!rst && (!$onehot0(bus.gnt) || bus.busy !== (|bus.gnt))) begin
      $error("FAIL gnt_invariant got=gnt %b busy %b exp=onehot0 and busy==|gnt", bus.gnt, bus.busy);
    end
  end
endmodule
